branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised successor to the core's static "backwards taken, forwards not taken" branch prediction.
- Holds a bimodal table of saturating counters indexed by PC. It is looked up combinationally from DECODE and trained at branch resolution in EXECUTE.
- Also produces the mispredict flag and the redirect PC, plus saturating performance counters.
- MODE selects static BTFN, which keeps legacy behaviour, or dynamic prediction.

Parameters:
ENTRIES, 64, number of counter entries; must be a power of 2, minimum 2
COUNTER_BITS, 2, width of each saturating counter; minimum 1
MODE, 1, 0 = static BTFN (table unused), 1 = dynamic bimodal
STAT_W, 32, width of the performance counters

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
lookup_valid  input  1  DECODE holds a valid B-type instruction
lookup_pc  input  32  PC of that instruction
lookup_offset  input  32  sign-extended B-type immediate
predict_taken  output  1  prediction for the lookup
predict_target  output  32  lookup_pc + lookup_offset
update_valid  input  1  EXECUTE resolves a valid branch this cycle
update_pc  input  32  PC of the resolved branch
update_offset  input  32  sign-extended immediate of the resolved branch
update_taken  input  1  actual outcome from the ALU
update_predicted  input  1  predict_taken value carried down the pipe with the branch
mispredict  output  1  resolved outcome differs from the prediction
redirect_pc  output  32  correct next PC for the resolved branch
stat_branches  output  STAT_W  count of resolved branches
stat_mispredicts  output  STAT_W  count of mispredictions

Behaviour:
- IDX_W = log2(ENTRIES). Index = pc[IDX_W+1:2]; pc[1:0] is ignored.
- Counter encoding is unsigned 0..2^COUNTER_BITS-1. Predict taken when the MSB is 1.
- On reset, every table entry is set to 2^(COUNTER_BITS-1)-1 (weakly not-taken). For COUNTER_BITS=1 this is 0.
- On reset, stat_branches and stat_mispredicts are set to 0.
- Reset takes priority over an update in the same cycle, including reset arriving mid-stream.
- Lookup is purely combinational, with zero latency:
  - predict_taken = lookup_valid && (MODE==0 ? lookup_offset[31] : MSB of table[index(lookup_pc)]).
  - predict_taken = 0 whenever lookup_valid = 0.
  - predict_target = lookup_pc + lookup_offset, modulo 2^32, with wrap-around permitted. It is driven regardless of lookup_valid.
- Resolution outputs are combinational:
  - mispredict = update_valid && (update_taken != update_predicted).
  - redirect_pc = update_taken ? update_pc + update_offset : update_pc + 4, both modulo 2^32. It is valid only when mispredict = 1 and is otherwise don't-care but deterministic.
- Training happens on the rising edge when update_valid = 1 and MODE = 1:
  - If update_taken = 1, table[index(update_pc)] increments, saturating at its maximum.
  - If update_taken = 0, it decrements, saturating at 0.
  - In MODE 0 the table is never written.
- Simultaneous lookup and update to the same index: the lookup sees the pre-update value. There is no bypass, and the new value is visible from the next cycle.
- Simultaneous lookup and update to different indices are independent.
- Statistics update on each rising edge with update_valid = 1:
  - stat_branches increments by 1.
  - stat_mispredicts increments by 1 if mispredict = 1.
  - Both saturate at 2^STAT_W-1 and do not wrap.
- No stalls and no handshake back-pressure: one update per cycle maximum, accepted unconditionally.
- Aliasing is permitted: PCs sharing an index share a counter.

Test Plan:
1. Reset, MODE=1, COUNTER_BITS=2. Look up pc=0x100, offset=0x10 -> predict_taken=0, predict_target=0x110; stat_branches=0, stat_mispredicts=0.
2. Two updates for pc=0x100, taken=1, predicted=0 -> counter goes 01->10->11; both updates assert mispredict with redirect_pc=0x110; after them lookup pc=0x100 gives predict_taken=1; stat_mispredicts=2.
3. Saturation: from 11, two taken updates keep the counter at 11; then three not-taken updates take it 10->01->00, with predict_taken=0 after the second not-taken update; a further not-taken update holds at 00.
4. Same-cycle lookup and update at pc=0x200 (counter 01, update taken) -> predict_taken=0 that cycle and 1 the next cycle. Aliasing with ENTRIES=64: an update at pc=0x100 changes the prediction for pc=0x200 (index 0 for both)... checks index = pc[7:2], so 0x100 and 0x200 both map to index 0 and share a counter.
5. MODE=0: offset=0xFFFFFFF0 at pc=0x8 -> predict_taken=1, target=0xFFFFFFF8 (wrap); offset=0x8 -> predict_taken=0; a not-taken update with predicted=1 -> mispredict=1, redirect_pc=0xC, table unchanged.
6. STAT_W=4: 20 updates -> stat_branches holds at 15. Reset asserted together with update_valid=1 -> counters and table return to reset values.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Lookup (DECODE) and resolution (EXECUTE) signals of the branch predictor.
interface branch_predictor_if #(
    parameter int unsigned STAT_W = 32
) ();
    logic              lookup_valid;
    logic [31:0]       lookup_pc;
    logic [31:0]       lookup_offset;
    logic              predict_taken;
    logic [31:0]       predict_target;
    logic              update_valid;
    logic [31:0]       update_pc;
    logic [31:0]       update_offset;
    logic              update_taken;
    logic              update_predicted;
    logic              mispredict;
    logic [31:0]       redirect_pc;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispredicts;

    // Pipeline side: drives lookups and resolutions, consumes predictions.
    modport master (
        output lookup_valid, lookup_pc, lookup_offset,
        output update_valid, update_pc, update_offset, update_taken, update_predicted,
        input  predict_taken, predict_target, mispredict, redirect_pc,
        input  stat_branches, stat_mispredicts
    );

    // Predictor side.
    modport slave (
        input  lookup_valid, lookup_pc, lookup_offset,
        input  update_valid, update_pc, update_offset, update_taken, update_predicted,
        output predict_taken, predict_target, mispredict, redirect_pc,
        output stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal branch predictor with static BTFN fallback, mispredict/redirect
// generation and saturating performance counters.
module branch_predictor #(
    parameter int unsigned ENTRIES      = 64,
    parameter int unsigned COUNTER_BITS = 2,
    parameter int unsigned MODE         = 1,
    parameter int unsigned STAT_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    branch_predictor_if.slave   bp
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam logic [COUNTER_BITS-1:0] CNT_MAX  = '1;
    localparam logic [COUNTER_BITS-1:0] CNT_INIT =
        COUNTER_BITS'((64'd1 << (COUNTER_BITS - 1)) - 64'd1);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [COUNTER_BITS-1:0] table_q [ENTRIES];
    logic [COUNTER_BITS-1:0] upd_cnt_d;
    logic [IDX_W-1:0]        lkp_idx;
    logic [IDX_W-1:0]        upd_idx;
    logic [STAT_W-1:0]       stat_br_q;
    logic [STAT_W-1:0]       stat_br_d;
    logic [STAT_W-1:0]       stat_mp_q;
    logic [STAT_W-1:0]       stat_mp_d;
    logic                    mispredict_c;

    assign lkp_idx = bp.lookup_pc[IDX_W+1:2];
    assign upd_idx = bp.update_pc[IDX_W+1:2];

    // Zero-latency prediction: sign of the offset (BTFN) or counter MSB.
    always_comb begin
        bp.predict_taken = 1'b0;
        if (bp.lookup_valid) begin
            if (MODE == 0) begin
                bp.predict_taken = bp.lookup_offset[31];
            end else begin
                bp.predict_taken = table_q[lkp_idx][COUNTER_BITS-1];
            end
        end
    end

    assign bp.predict_target = bp.lookup_pc + bp.lookup_offset;

    // Resolution: mispredict flag and the correct fall-through/taken PC.
    assign mispredict_c     = bp.update_valid && (bp.update_taken != bp.update_predicted);
    assign bp.mispredict    = mispredict_c;
    assign bp.redirect_pc   = bp.update_taken ? (bp.update_pc + bp.update_offset)
                                              : (bp.update_pc + 32'd4);

    // Saturating step of the counter being trained.
    always_comb begin
        upd_cnt_d = table_q[upd_idx];
        if (bp.update_taken) begin
            if (upd_cnt_d != CNT_MAX) begin
                upd_cnt_d = upd_cnt_d + COUNTER_BITS'(1);
            end
        end else if (upd_cnt_d != '0) begin
            upd_cnt_d = upd_cnt_d - COUNTER_BITS'(1);
        end
    end

    // Counter table: reset to weakly not-taken, trained only in dynamic mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_q[i] <= CNT_INIT;
            end
        end else if (bp.update_valid && (MODE == 1)) begin
            table_q[upd_idx] <= upd_cnt_d;
        end
    end

    // Next values of the saturating statistics counters.
    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (bp.update_valid) begin
            if (stat_br_q != STAT_MAX) begin
                stat_br_d = stat_br_q + STAT_W'(1);
            end
            if (mispredict_c && (stat_mp_q != STAT_MAX)) begin
                stat_mp_d = stat_mp_q + STAT_W'(1);
            end
        end
    end

    // Statistics registers; reset wins over a same-cycle update.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign bp.stat_branches    = stat_br_q;
    assign bp.stat_mispredicts = stat_mp_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: three predictor configurations share one stimulus stream
// and are checked against an array-based reference model.
module tb_branch_predictor;
    localparam int NDUT = 3;
    // Configurations: [0] dynamic 64x2b, [1] static BTFN, [2] dynamic 16x3b with 4-bit stats.
    localparam int M_ENT  [NDUT] = '{64, 64, 16};
    localparam int M_CB   [NDUT] = '{2, 2, 3};
    localparam int M_MODE [NDUT] = '{1, 0, 1};
    localparam int M_SW   [NDUT] = '{32, 32, 4};

    typedef struct packed {
        logic [NDUT-1:0]       pt;
        logic [31:0]           tgt;
        logic                  mis;
        logic [31:0]           rpc;
        logic [NDUT-1:0][31:0] sb;
        logic [NDUT-1:0][31:0] sm;
    } exp_t;

    logic clk;
    logic rst;
    logic lv, uv, ut, up;
    logic [31:0] lpc, loff, upc, uoff;

    int     n_vec;
    int     n_miss;
    exp_t   sb_q[$];

    int     m_cnt [NDUT][64];
    longint m_sb  [NDUT];
    longint m_sm  [NDUT];

    branch_predictor_if #(.STAT_W(32)) if_a ();
    branch_predictor_if #(.STAT_W(32)) if_b ();
    branch_predictor_if #(.STAT_W(4))  if_c ();

    assign if_a.lookup_valid = lv;  assign if_b.lookup_valid = lv;  assign if_c.lookup_valid = lv;
    assign if_a.lookup_pc = lpc;    assign if_b.lookup_pc = lpc;    assign if_c.lookup_pc = lpc;
    assign if_a.lookup_offset = loff; assign if_b.lookup_offset = loff; assign if_c.lookup_offset = loff;
    assign if_a.update_valid = uv;  assign if_b.update_valid = uv;  assign if_c.update_valid = uv;
    assign if_a.update_pc = upc;    assign if_b.update_pc = upc;    assign if_c.update_pc = upc;
    assign if_a.update_offset = uoff; assign if_b.update_offset = uoff; assign if_c.update_offset = uoff;
    assign if_a.update_taken = ut;  assign if_b.update_taken = ut;  assign if_c.update_taken = ut;
    assign if_a.update_predicted = up; assign if_b.update_predicted = up; assign if_c.update_predicted = up;

    branch_predictor #(.ENTRIES(64), .COUNTER_BITS(2), .MODE(1), .STAT_W(32)) dut_a (
        .clk(clk), .reset(rst), .bp(if_a));
    branch_predictor #(.ENTRIES(64), .COUNTER_BITS(2), .MODE(0), .STAT_W(32)) dut_b (
        .clk(clk), .reset(rst), .bp(if_b));
    branch_predictor #(.ENTRIES(16), .COUNTER_BITS(3), .MODE(1), .STAT_W(4)) dut_c (
        .clk(clk), .reset(rst), .bp(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int m_idx(input int d, input logic [31:0] pc);
        return int'((pc >> 2) % 32'(M_ENT[d]));
    endfunction

    task automatic m_reset();
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 64; i++) m_cnt[d][i] = (1 << (M_CB[d] - 1)) - 1;
            m_sb[d] = 0;
            m_sm[d] = 0;
        end
    endtask

    // What the clock edge does with the inputs currently applied.
    task automatic m_commit();
        longint smax;
        int     k;
        if (rst) begin
            m_reset();
            return;
        end
        if (!uv) return;
        for (int d = 0; d < NDUT; d++) begin
            smax = (longint'(1) << M_SW[d]) - 1;
            if (m_sb[d] < smax) m_sb[d]++;
            if ((ut != up) && (m_sm[d] < smax)) m_sm[d]++;
            if (M_MODE[d] == 1) begin
                k = m_idx(d, upc);
                if (ut) begin
                    if (m_cnt[d][k] < (1 << M_CB[d]) - 1) m_cnt[d][k]++;
                end else if (m_cnt[d][k] > 0) begin
                    m_cnt[d][k]--;
                end
            end
        end
    endtask

    function automatic exp_t m_expect();
        exp_t e;
        for (int d = 0; d < NDUT; d++) begin
            if (!lv)                 e.pt[d] = 1'b0;
            else if (M_MODE[d] == 0) e.pt[d] = loff[31];
            else                     e.pt[d] = (m_cnt[d][m_idx(d, lpc)] >= (1 << (M_CB[d] - 1)));
            e.sb[d] = 32'(m_sb[d]);
            e.sm[d] = 32'(m_sm[d]);
        end
        e.tgt = lpc + loff;
        e.mis = uv && (ut != up);
        e.rpc = ut ? (upc + uoff) : (upc + 32'd4);
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic l_v, input logic [31:0] l_pc, input logic [31:0] l_off,
                        input logic u_v, input logic [31:0] u_pc, input logic [31:0] u_off,
                        input logic u_t, input logic u_p);
        @(posedge clk);
        m_commit();
        #1;
        rst = r; lv = l_v; lpc = l_pc; loff = l_off;
        uv = u_v; upc = u_pc; uoff = u_off; ut = u_t; up = u_p;
        if (lv || uv) sb_q.push_back(m_expect());
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, d, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [NDUT-1:0]       a_pt, a_mis;
        logic [NDUT-1:0][31:0] a_tgt, a_rpc, a_sb, a_sm;
        if (lv || uv) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL scoreboard_empty @%0t: got no expected entry, required one", $time);
            end else begin
                e = sb_q.pop_front();
                a_pt  = {if_c.predict_taken, if_b.predict_taken, if_a.predict_taken};
                a_mis = {if_c.mispredict, if_b.mispredict, if_a.mispredict};
                a_tgt = {if_c.predict_target, if_b.predict_target, if_a.predict_target};
                a_rpc = {if_c.redirect_pc, if_b.redirect_pc, if_a.redirect_pc};
                a_sb  = {32'(if_c.stat_branches), if_b.stat_branches, if_a.stat_branches};
                a_sm  = {32'(if_c.stat_mispredicts), if_b.stat_mispredicts, if_a.stat_mispredicts};
                for (int d = 0; d < NDUT; d++) begin
                    check("predict_taken", d, 64'(a_pt[d]), 64'(e.pt[d]));
                    check("predict_target", d, 64'(a_tgt[d]), 64'(e.tgt));
                    check("mispredict", d, 64'(a_mis[d]), 64'(e.mis));
                    if (e.mis) check("redirect_pc", d, 64'(a_rpc[d]), 64'(e.rpc));
                    check("stat_branches", d, 64'(a_sb[d]), 64'(e.sb[d]));
                    check("stat_mispredicts", d, 64'(a_sm[d]), 64'(e.sm[d]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_vec = 0; n_miss = 0;
        rst = 1'b1; lv = 1'b0; uv = 1'b0; ut = 1'b0; up = 1'b0;
        lpc = '0; loff = '0; upc = '0; uoff = '0;
        m_reset();

        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        // Post-reset lookup.
        step(1'b0, 1'b1, 32'h100, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        // Train up from weakly not-taken.
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h100, 32'h10, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h100, 32'h10, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h100, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        // Saturation both ways with same-cycle lookups of the trained entry.
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 32'h100, 32'h10, 1'b1, 32'h100, 32'h10, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h100, 32'h10, 1'b1, 32'h100, 32'h10, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'h100, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        // Same-cycle lookup/update at 0x200, then aliasing through 0x100.
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h200, 32'h4, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h200, 32'h4, 1'b1, 32'h200, 32'h4, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h200, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h200, 32'h4, 1'b1, 32'h100, 32'h8, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'h200, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        // Backward/forward offsets, wrap-around target, not-taken mispredict.
        step(1'b0, 1'b1, 32'h8, 32'hFFFF_FFF0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h8, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h8, 32'hFFFF_FFF0, 1'b1, 32'h8, 32'hFFFF_FFF0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'h8, 32'hFFFF_FFF0, 1'b1, 32'hFFFF_FFFC, 32'h8, 1'b1, 1'b0);
        // Stats saturation (4-bit configuration), then reset racing an update.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 32'h100, 32'h10, 1'b1, 32'h100, 32'h10, 1'b1, 1'b0);
        step(1'b1, 1'b1, 32'h100, 32'h10, 1'b1, 32'h100, 32'h10, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h100, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Randomised traffic over a small PC window to force collisions.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] u_pc, l_pc;
            u_pc = 32'($urandom_range(0, 1023));
            l_pc = ($urandom_range(0, 1) == 1) ? u_pc : 32'($urandom_range(0, 1023));
            step(1'($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 3) != 0), l_pc, 32'($urandom),
                 1'($urandom_range(0, 3) != 0), u_pc, 32'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        idle();
        idle();
        @(posedge clk);
        if (sb_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
